// File: rtl/fpu_addsub_seq_pkg.sv
// Shared FPU definitions for the sequential binary32 add/subtract unit.
package fpu_addsub_seq_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  // Bit positions within FLAGS = {INV, OVF, UNF, INX}
  localparam int unsigned FLG_INV = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
  } unp_t;

  // Denormals flush to signed zero; flip applies the effective-subtract sign.
  function automatic unp_t unpack_op(input logic [31:0] f, input logic flip);
    unp_t u;
    u.sign = f[31] ^ flip;
    u.exp  = {2'b00, f[30:23]};
    u.sig  = (f[30:23] == 8'd0) ? 24'd0 : {1'b1, f[22:0]};
    if (f[30:23] == 8'd0) u.exp = '0;
    return u;
  endfunction

endpackage

// File: rtl/fpu_addsub_seq_cla.sv
// 25-bit carry-lookahead adder shared by the significand add and rounding passes.
module cla_25 (
  input  logic [24:0] a_i,
  input  logic [24:0] b_i,
  input  logic        cin_i,
  output logic [24:0] sum_o
);
  logic [24:0] g, p;
  logic [25:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = cin_i;
    for (int unsigned i = 0; i < 25; i++) c[i+1] = g[i] | (p[i] & c[i]);
    sum_o = p ^ c[24:0];
  end
endmodule

// File: rtl/fpu_addsub_seq_lzc.sv
// Leading-zero counter over a 24-bit significand; all-zero input yields 24.
module lzc_24 (
  input  logic [23:0] v_i,
  output logic [4:0]  cnt_o
);
  always_comb begin
    cnt_o = 5'd24;
    for (int unsigned i = 0; i < 24; i++)
      if (v_i[i]) cnt_o = 5'(23 - i);
  end
endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle binary32 add/subtract sequencing one shared CLA through
// unpack, align, add, normalize, round and pack.
module fpu_addsub_seq
  import fpu_addsub_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        SUB,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        READY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [3:0]  FLAGS
);
  localparam logic [7:0]        EXP_ONES = 8'(EXP_MAX);
  localparam logic signed [9:0] EXP_TOP  = 10'(EXP_MAX);
  localparam logic [3:0] F_INV = 4'(1 << FLG_INV);
  localparam logic [3:0] F_OVF = 4'(1 << FLG_OVF);
  localparam logic [3:0] F_UNF = 4'(1 << FLG_UNF);
  localparam logic [3:0] F_INX = 4'(1 << FLG_INX);

  state_e             state_q;
  logic               ready_q, done_q, sub_q, eff_q, xs_q, inx_q, spec_q;
  logic [31:0]        a_q, b_q, result_q, spec_res_q;
  logic [3:0]         flags_q, spec_flg_q;
  logic [23:0]        xsig_q, ysig_q;
  logic [24:0]        sig_q;
  logic [2:0]         grs_q;
  logic [9:0]         d_q;
  logic signed [9:0]  exp_q;

  unp_t        ua, ub;
  logic        eff, a_big, special;
  logic [31:0] sp_res;
  logic [3:0]  sp_flg;

  always_comb begin
    ua      = unpack_op(a_q, 1'b0);
    ub      = unpack_op(b_q, sub_q);
    eff     = ua.sign ^ ub.sign;
    a_big   = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
    special = 1'b1;
    sp_res  = '0;
    sp_flg  = '0;
    if (((a_q[30:23] == EXP_ONES) && (a_q[22:0] != '0)) ||
        ((b_q[30:23] == EXP_ONES) && (b_q[22:0] != '0)) ||
        ((a_q[30:23] == EXP_ONES) && (b_q[30:23] == EXP_ONES) && eff)) begin
      sp_res = QNAN;
      sp_flg = F_INV;
    end else if (a_q[30:23] == EXP_ONES) sp_res = {ua.sign, EXP_ONES, 23'd0};
    else if (b_q[30:23] == EXP_ONES)     sp_res = {ub.sign, EXP_ONES, 23'd0};
    else if ((ua.sig == '0) && (ub.sig == '0)) sp_res = {ua.sign & ub.sign, 31'd0};
    else special = 1'b0;
  end

  // Alignment: {sig, G, R, S} window on top, everything shifted past S is sticky.
  logic [53:0] al_sh;
  logic        al_big;
  logic [23:0] al_sig;
  logic [2:0]  al_grs;

  always_comb begin
    al_sh  = {ysig_q, 30'd0} >> d_q;
    al_big = d_q >= 10'd27;
    al_sig = al_big ? 24'd0 : al_sh[53:30];
    al_grs = al_big ? {2'b00, |ysig_q} : {al_sh[29:28], al_sh[27] | (|al_sh[26:0])};
  end

  logic [4:0]  lz;
  logic [26:0] nrm_sh;

  lzc_24 u_lzc (.v_i(sig_q[23:0]), .cnt_o(lz));
  assign nrm_sh = {sig_q[23:0], grs_q} << lz;

  logic [24:0] cla_a, cla_b, cla_sum;
  logic        cla_cin, round_up;

  assign round_up = grs_q[2] & (grs_q[1] | grs_q[0] | sig_q[0]);

  always_comb begin
    if (state_q == S_ROUND) begin
      cla_a   = {1'b0, sig_q[23:0]};
      cla_b   = '0;
      cla_cin = round_up;
    end else begin
      cla_a   = {1'b0, xsig_q};
      cla_b   = eff_q ? ~sig_q : sig_q;
      cla_cin = eff_q & (grs_q == 3'd0);
    end
  end

  cla_25 u_cla (.a_i(cla_a), .b_i(cla_b), .cin_i(cla_cin), .sum_o(cla_sum));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (START) begin
          a_q     <= A;
          b_q     <= B;
          sub_q   <= SUB;
          ready_q <= 1'b0;
          state_q <= S_UNPACK;
        end
        S_UNPACK: begin
          spec_q     <= special;
          spec_res_q <= sp_res;
          spec_flg_q <= sp_flg;
          inx_q      <= 1'b0;
          eff_q      <= eff;
          grs_q      <= '0;
          xs_q       <= a_big ? ua.sign : ub.sign;
          xsig_q     <= a_big ? ua.sig : ub.sig;
          ysig_q     <= a_big ? ub.sig : ua.sig;
          exp_q      <= a_big ? ua.exp : ub.exp;
          d_q        <= a_big ? ua.exp - ub.exp : ub.exp - ua.exp;
          state_q    <= special ? S_PACK : S_ALIGN;
        end
        S_ALIGN: begin
          sig_q   <= {1'b0, al_sig};
          grs_q   <= al_grs;
          state_q <= S_ADD;
        end
        S_ADD: begin
          sig_q <= cla_sum;
          // 8 - GRS wraps to 0 - GRS in three bits
          if (eff_q && (grs_q != 3'd0)) grs_q <= 3'd0 - grs_q;
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (sig_q[24]) begin
            sig_q   <= {1'b0, sig_q[24:1]};
            grs_q   <= {sig_q[0], grs_q[2], grs_q[1] | grs_q[0]};
            exp_q   <= exp_q + 10'sd1;
            state_q <= S_ROUND;
          end else if ((sig_q == '0) && (grs_q == '0)) begin
            spec_q     <= 1'b1;
            spec_res_q <= '0;
            spec_flg_q <= '0;
            state_q    <= S_PACK;
          end else begin
            sig_q   <= {1'b0, nrm_sh[26:3]};
            grs_q   <= nrm_sh[2:0];
            exp_q   <= exp_q - 10'(lz);
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          inx_q <= |grs_q;
          if (cla_sum[24]) begin
            sig_q <= {1'b0, cla_sum[24:1]};
            exp_q <= exp_q + 10'sd1;
          end else sig_q <= cla_sum;
          state_q <= S_PACK;
        end
        S_PACK: begin
          if (spec_q) begin
            result_q <= spec_res_q;
            flags_q  <= spec_flg_q;
          end else if (exp_q >= EXP_TOP) begin
            result_q <= {xs_q, EXP_ONES, 23'd0};
            flags_q  <= F_OVF | F_INX;
          end else if (exp_q <= 10'sd0) begin
            result_q <= {xs_q, 31'd0};
            flags_q  <= F_UNF | F_INX;
          end else begin
            result_q <= {xs_q, exp_q[7:0], sig_q[22:0]};
            flags_q  <= inx_q ? F_INX : 4'd0;
          end
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign READY  = ready_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign FLAGS  = flags_q;
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Self-checking bench for fpu_addsub_seq: vector table plus handshake/reset sequences.
module tb_fpu_addsub_seq;
  import fpu_addsub_seq_pkg::*;

  localparam logic [31:0] ONE = {1'b0, 8'(EXP_BIAS), 23'd0};

  logic        CLK = 1'b0;
  logic        RST_N, START, SUB;
  logic [31:0] A, B, RESULT;
  logic        READY, DONE;
  logic [3:0]  FLAGS;

  fpu_addsub_seq dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SUB(SUB), .A(A), .B(B),
    .READY(READY), .DONE(DONE), .RESULT(RESULT), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        sub;
    logic [31:0] a, b, res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          due;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[18];
  int checks = 0, failures = 0, dones = 0, issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard consumer: every DONE must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (DONE) begin
      dones++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got DONE=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", RESULT, e.res);
        chk("flags", {28'd0, FLAGS}, {28'd0, e.flg});
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic issue(input vec_t v);
    int n = 0;
    while (!READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!READY) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got READY=0 expected 1 (cycle %0d)", cyc);
    end
    START = 1'b1;
    SUB   = v.sub;
    A     = v.a;
    B     = v.b;
    sbq.push_back('{res: v.res, flg: v.flg, due: cyc + 1 + v.lat});
    issued++;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, ONE,          ONE,          32'h4000_0000, 4'h0, 6};
    vecs[1]  = '{1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000, 4'h0, 5};
    vecs[2]  = '{1'b1, 32'h4000_0000, ONE,          ONE,           4'h0, 6};
    vecs[3]  = '{1'b0, ONE,          32'h3380_0000, ONE,           4'h1, 6};
    vecs[4]  = '{1'b0, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 4'h1, 6};
    vecs[5]  = '{1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4'h5, 6};
    vecs[6]  = '{1'b1, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'h8, 2};
    vecs[7]  = '{1'b0, 32'h7FC0_0001, ONE,          32'h7FC0_0000, 4'h8, 2};
    vecs[8]  = '{1'b0, 32'h7F80_0000, ONE,          32'h7F80_0000, 4'h0, 2};
    vecs[9]  = '{1'b1, ONE,          32'h7F80_0000, 32'hFF80_0000, 4'h0, 2};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'h0, 2};
    vecs[11] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'h0, 2};
    vecs[12] = '{1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'h0, 2};
    vecs[13] = '{1'b0, ONE,          32'hBF80_0000, 32'h0000_0000, 4'h0, 5};
    vecs[14] = '{1'b0, ONE,          32'h4000_0000, 32'h4040_0000, 4'h0, 6};
    vecs[15] = '{1'b1, ONE,          32'h4040_0000, 32'hC000_0000, 4'h0, 6};
    vecs[16] = '{1'b1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 4'h3, 6};
    vecs[17] = '{1'b1, ONE,          32'h3300_0000, ONE,           4'h1, 6};

    RST_N = 1'b0; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", {31'd0, READY}, 32'd1);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_flags", {28'd0, FLAGS}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i]);
      drain();
    end

    // Busy START pulses in cycles 1..5 must be ignored
    issue(vecs[14]);
    for (int i = 1; i <= 5; i++) begin
      chk("ready_busy", {31'd0, READY}, 32'd0);
      START = 1'b1;
      SUB   = 1'($urandom);
      A     = $urandom;
      B     = $urandom;
      @(negedge CLK);
    end
    START = 1'b0;
    drain();
    repeat (10) @(negedge CLK);
    chk("busy_done_count", dones, issued);

    // Reset while the op sits in ADD: dropped, no DONE, outputs cleared
    issue(vecs[0]);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_ready", {31'd0, READY}, 32'd1);
    chk("midrst_done", {31'd0, DONE}, 32'd0);
    chk("midrst_result", RESULT, 32'd0);
    chk("midrst_flags", {28'd0, FLAGS}, 32'd0);
    RST_N = 1'b1;
    void'(sbq.pop_back());
    issued--;
    repeat (12) @(negedge CLK);
    chk("midrst_done_count", dones, issued);

    // Back-to-back: second START in the first op's DONE cycle
    issue(vecs[0]);
    begin
      int n = 0;
      while (!DONE && n < 20) begin
        @(negedge CLK);
        n++;
      end
    end
    chk("b2b_ready_in_done", {31'd0, READY}, 32'd1);
    issue(vecs[15]);
    drain();
    repeat (4) @(negedge CLK);
    chk("final_done_count", dones, issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpu_addsub_seq.md
# fpu_addsub_seq

Multi-cycle IEEE-754 single-precision add/subtract controller for the FPU. It sequences one shared 25-bit carry-lookahead adder through unpack, align, significand add, normalize, round and pack. The adder is used twice per operation: once for the significand sum/difference and once for the rounding increment. The block sits between the FPU issue logic (START/READY handshake) and the result writeback (DONE pulse).

## Interface
- No parameters; all widths are fixed by binary32.
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset; synchronous, active-low
- START  in  1  request; accepted only on an edge where READY=1
- SUB  in  1  0: A+B, 1: A−B; sampled with START
- A  in  32  operand A, binary32; sampled with START
- B  in  32  operand B, binary32; sampled with START
- READY  out  1  idle, able to accept
- DONE  out  1  one-cycle pulse; RESULT/FLAGS valid from this cycle
- RESULT  out  32  binary32 result; held until the next accept
- FLAGS  out  4  {INV, OVF, UNF, INX}; held with RESULT

## Operation
- States: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK.
- IDLE→UNPACK on START&READY. START while busy is ignored, not queued.
- UNPACK:
  - Denormal inputs are flushed to signed zero.
  - Effective op = SUB ^ signA ^ signB.
  - Swap operands so the larger magnitude (exponent, then significand) is X.
  - Specials bypass to PACK:
    - NaN input, or Inf−Inf effective subtract: 0x7FC00000, INV=1.
    - Inf: that Inf with its sign.
    - Both zero: +0, or −0 when both effective signs are negative.
- ALIGN:
  - Shift Y's 24-bit significand right by d = expX−expY, barrel, one cycle.
  - Keep guard, round and sticky (GRS). d≥27 makes Y's significand zero and S = OR of Y.
- ADD: one adder pass on 25-bit operands {0,sigX} and {0,sigY}.
  - Add: CIN=0; GRS passes through.
  - Subtract: B input = ~{0,sigY}.
    - If GRS≠0: CIN=0 and GRS ← 8−GRS.
    - If GRS=0: CIN=1.
  - The swap guarantees a non-negative result.
- NORM:
  - Bit 24 set: shift right 1, fold the dropped bit into S, exp+1.
  - Otherwise shift left by the leading-zero count of bits 23:0 (one cycle) and decrement exp by that count; GRS shifts in.
  - Exact zero difference: result +0, jump to PACK.
- ROUND (RNE):
  - round_up = G & (R | S | lsb).
  - Second adder pass: A={0,sig}, B=0, CIN=round_up.
  - Carry into bit 24: shift right 1, exp+1.
  - INX = G|R|S.
- PACK:
  - exp≥255: ±Inf, OVF=1, INX=1.
  - exp≤0: signed zero, UNF=1, INX=1.
  - Otherwise assemble the result.
  - Register RESULT and FLAGS, pulse DONE, return to IDLE.
- Exponent arithmetic uses a 10-bit signed internal width. It never uses the shared adder.

## Timing
- Cycle 0 is the accepting edge.
- Normal path: DONE is high in cycle 6, fixed.
- Special or bypass path: DONE is high in cycle 2 (UNPACK→PACK).
- Exact-zero path: DONE is high in cycle 5 (NORM→PACK).
- READY is low from cycle 1 until DONE, and high again in the DONE cycle. A START in the DONE cycle is accepted, so back-to-back operations are allowed.
- Reset (RST_N=0 at any edge, including mid-operation):
  - Next cycle: state IDLE, READY=1, DONE=0, RESULT=0, FLAGS=0.
  - The in-flight operation is dropped with no DONE pulse.

## Structure
- Shared FPU package holds:
  - Constants: EXP_BIAS=127, EXP_MAX=255, QNAN=0x7FC00000.
  - A state enum.
  - An unpacked-operand struct {sign, exp[9:0], sig[23:0]}.
  - A FLAGS bit-index constant.
- Sub-modules:
  - One existing cla_25 instance, with inputs muxed by state.
  - lzc_24 leading-zero counter as a small sub-module.

## Test plan
- 0x3F800000 + 0x3F800000 (SUB=0) → 0x40000000, FLAGS=0, DONE in cycle 6.
- 0x3FC00000 − 0x3FC00000 → 0x00000000, FLAGS=0, DONE in cycle 5. Also 0x40000000 − 0x3F800000 → 0x3F800000.
- 0x3F800000 + 0x33800000 → 0x3F800000, INX=1 (tie to even). 0x3F800001 + 0x33800000 → 0x3F800002, INX=1.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, OVF=1, INX=1. 0x7F800000 − 0x7F800000 → 0x7FC00000, INV=1, DONE in cycle 2.
- START pulsed in cycles 1–5 while busy → ignored, single DONE. RST_N=0 during ADD → READY=1 next cycle, no DONE, RESULT=0.
- Back-to-back: second START in the first op's DONE cycle → second DONE six cycles later with the correct result.
